// File: rtl/apa102_matrix_scroller.sv
// APA102-style serpentine LED-matrix driver: double-buffered monochrome glyph rendered with
// foreground/background colours, programmable bit-clock divider, continuous mode and scrolling.
module apa102_matrix_scroller #(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int DIV        = 1,
    parameter int START_BITS = 32,
    parameter int END_BITS   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    scroll_en,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic [31:0]             fg_color,
    input  logic [31:0]             bg_color,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    busy,
    output logic                    frame_done,
    output logic [$clog2(COLS)-1:0] offset
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_PIXELS = 3'd2;
    localparam logic [2:0] S_END    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      r_state;
    logic [31:0]     r_div_cnt;
    logic [31:0]     r_bit_cnt;
    logic            r_half;
    logic [4:0]      r_wbit;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_offset;
    logic [COLS-1:0] r_shadow [ROWS];
    logic [COLS-1:0] r_active [ROWS];
    logic [28:0]     r_fg;
    logic [28:0]     r_bg;

    logic            w_load;
    logic            w_shift;
    logic            w_tick;
    logic [CW-1:0]   w_col_phys;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_gcol;
    logic            w_lit;
    logic [31:0]     w_word;

    assign w_load  = ((r_state == S_IDLE) && start) || ((r_state == S_DONE) && cont);
    assign w_shift = (r_state == S_START) || (r_state == S_PIXELS) || (r_state == S_END);
    assign w_tick  = (r_div_cnt == 32'(DIV - 1));

    // Even strip rows run right-to-left across the matrix, odd rows left-to-right.
    assign w_col_phys = r_row[0] ? r_col : (LAST_COL - r_col);
    assign w_sum      = {1'b0, w_col_phys} + {1'b0, r_offset};
    assign w_gcol     = (w_sum >= (CW + 1)'(COLS)) ? CW'(w_sum - (CW + 1)'(COLS))
                                                   : w_sum[CW-1:0];
    // Glyph rows are stored MSB = column 0.
    assign w_lit      = r_active[r_row][LAST_COL - w_gcol];
    assign w_word     = {3'b111, (w_lit ? r_fg : r_bg)};

    assign sclk       = r_half;
    assign sdata      = (r_state == S_PIXELS) ? w_word[5'd31 - r_wbit] : 1'b0;
    assign busy       = w_shift || ((r_state == S_DONE) && cont);
    assign frame_done = (r_state == S_DONE);
    assign offset     = r_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_half    <= 1'b0;
            r_wbit    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_offset  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_START;
                        r_div_cnt <= '0;
                        r_half    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                S_START, S_PIXELS, S_END: begin
                    if (!w_tick) begin
                        r_div_cnt <= r_div_cnt + 32'd1;
                    end else begin
                        r_div_cnt <= '0;
                        r_half    <= ~r_half;
                        // A bit ends after its high phase; advance to the next bit.
                        if (r_half) begin
                            if (r_state == S_START) begin
                                if (r_bit_cnt == 32'(START_BITS - 1)) begin
                                    r_state <= S_PIXELS;
                                    r_wbit  <= '0;
                                    r_row   <= '0;
                                    r_col   <= '0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 32'd1;
                                end
                            end else if (r_state == S_PIXELS) begin
                                if (r_wbit == 5'd31) begin
                                    r_wbit <= '0;
                                    if (r_col == LAST_COL) begin
                                        r_col <= '0;
                                        if (r_row == LAST_ROW) begin
                                            r_state   <= S_END;
                                            r_bit_cnt <= '0;
                                        end else begin
                                            r_row <= r_row + 1'b1;
                                        end
                                    end else begin
                                        r_col <= r_col + 1'b1;
                                    end
                                end else begin
                                    r_wbit <= r_wbit + 5'd1;
                                end
                            end else begin
                                if (r_bit_cnt == 32'(END_BITS - 1)) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 32'd1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (scroll_en) begin
                        r_offset <= (r_offset == LAST_COL) ? '0 : r_offset + 1'b1;
                    end
                    if (cont) begin
                        r_state   <= S_START;
                        r_div_cnt <= '0;
                        r_half    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The snapshot copies the old shadow contents, so a same-cycle write lands after the copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_fg <= '0;
            r_bg <= '0;
        end else begin
            if (w_load) begin
                for (int i = 0; i < ROWS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_fg <= fg_color[28:0];
                r_bg <= bg_color[28:0];
            end
            if (wr_en && (32'(wr_row) < 32'(ROWS))) begin
                r_shadow[wr_row] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_apa102_matrix_scroller.sv
// Scoreboard bench: expected LED words are queued when a frame is launched and compared as the
// strip bits are captured on sclk rising edges; a second DIV=2 instance checks bit timing.
module tb_apa102_matrix_scroller;

    localparam int COLS       = 8;
    localparam int ROWS       = 8;
    localparam int START_BITS = 32;
    localparam int END_BITS   = 64;
    localparam int PIX_BITS   = 32 * ROWS * COLS;
    localparam int FRAME_BITS = START_BITS + PIX_BITS + END_BITS;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic        cont;
    logic        scroll_en;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic [31:0] fg_color;
    logic [31:0] bg_color;
    logic        sclk, sdata, busy, frame_done;
    logic [2:0]  offset;
    logic        sclk2, sdata2, busy2, frame_done2;
    logic [2:0]  offset2;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done2 = 0;
    logic [31:0] q [$];
    logic [7:0]  tb_shadow [ROWS];
    int          tb_off = 0;
    logic [31:0] tb_fg, tb_bg;

    always #5 clk = ~clk;

    apa102_matrix_scroller #(.COLS(COLS), .ROWS(ROWS), .DIV(1)) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .scroll_en(scroll_en),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .fg_color(fg_color),
        .bg_color(bg_color), .sclk(sclk), .sdata(sdata), .busy(busy),
        .frame_done(frame_done), .offset(offset)
    );

    apa102_matrix_scroller #(.COLS(COLS), .ROWS(ROWS), .DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cont(1'b0), .scroll_en(1'b0),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .fg_color(fg_color),
        .bg_color(bg_color), .sclk(sclk2), .sdata(sdata2), .busy(busy2),
        .frame_done(frame_done2), .offset(offset2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int p);
        int r, k, c, gc;
        logic [7:0] row;
        r   = p / COLS;
        k   = p % COLS;
        c   = (r % 2 == 0) ? (COLS - 1 - k) : k;
        gc  = (c + tb_off) % COLS;
        row = tb_shadow[r];
        return {3'b111, (row[COLS-1-gc] ? tb_fg[28:0] : tb_bg[28:0])};
    endfunction

    task automatic push_frame();
        for (int p = 0; p < ROWS * COLS; p++) q.push_back(exp_word(p));
    endtask

    task automatic write_row(input int row, input logic [7:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_row  = 3'(row);
        wr_data = data;
        tb_shadow[row] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_colors(input logic [31:0] fg, input logic [31:0] bg);
        fg_color = fg;
        bg_color = bg;
        tb_fg    = fg;
        tb_bg    = bg;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        push_frame();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!frame_done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic finish_single(input string tag);
        wait_done(FRAME_BITS * 2 + 50);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Main instance monitor: capture bits on sclk rising edges and score them.
    initial begin
        int n_edge, n_zero_err;
        logic prev;
        logic [31:0] sh, expw;
        n_edge = 0;
        n_zero_err = 0;
        prev = 1'b0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                chk("edges", 32'(n_edge), 32'(FRAME_BITS));
                chk("zero_bits", 32'(n_zero_err), 32'd0);
                n_edge = 0;
                n_zero_err = 0;
            end else if (!busy) begin
                n_edge = 0;
                n_zero_err = 0;
            end else if (sclk && !prev) begin
                if (n_edge < START_BITS || n_edge >= START_BITS + PIX_BITS) begin
                    if (sdata) n_zero_err++;
                end else begin
                    sh = {sh[30:0], sdata};
                    if ((n_edge - START_BITS) % 32 == 31) begin
                        chk("sb_avail", 32'(q.size() != 0), 32'd1);
                        if (q.size() != 0) begin
                            expw = q.pop_front();
                            chk("led_word", sh, expw);
                        end
                    end
                end
                n_edge++;
            end
            prev = sclk;
        end
    end

    // DIV=2 monitor: sclk period and sdata stability across each high phase.
    initial begin
        int n_edge2, since, per_err, stab_err;
        logic prev2, held;
        n_edge2 = 0;
        since = 0;
        per_err = 0;
        stab_err = 0;
        prev2 = 1'b0;
        held = 1'b0;
        forever begin
            @(negedge clk);
            since++;
            if (frame_done2) begin
                chk("div2_edges", 32'(n_edge2), 32'(FRAME_BITS));
                chk("div2_period", 32'(per_err), 32'd0);
                chk("div2_stable", 32'(stab_err), 32'd0);
                n_done2++;
                n_edge2 = 0;
                per_err = 0;
                stab_err = 0;
                since = 0;
            end else if (!busy2) begin
                n_edge2 = 0;
                per_err = 0;
                stab_err = 0;
                since = 0;
            end else if (sclk2 && !prev2) begin
                if (n_edge2 > 0 && since != 4) per_err++;
                since = 0;
                held = sdata2;
                n_edge2++;
            end else if (sclk2 && (sdata2 !== held)) begin
                stab_err++;
            end
            prev2 = sclk2;
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        cont = 1'b0;
        scroll_en = 1'b0;
        wr_en = 1'b0;
        wr_row = '0;
        wr_data = '0;
        for (int i = 0; i < ROWS; i++) tb_shadow[i] = '0;
        set_colors(32'h0000_0000, 32'h0000_0000);
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        reset = 1'b0;

        // All-zero glyph, bg=0: every word is 0xE0000000.
        pulse_start();
        chk("busy_started", 32'(busy), 32'd1);
        finish_single("blank");

        // Single lit pixel in row 0 column 0, then in row 1 column 0.
        set_colors(32'hFF00_00FF, 32'h0000_0000);
        write_row(0, 8'h80);
        pulse_start();
        finish_single("row0");
        write_row(0, 8'h00);
        write_row(1, 8'h80);
        pulse_start();
        finish_single("row1");

        // Mid-frame shadow write only affects the following frame; start while busy ignored.
        write_row(1, 8'h00);
        write_row(0, 8'h80);
        pulse_start();
        repeat (300) @(negedge clk);
        write_row(0, 8'hFF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_single("midwrite");
        pulse_start();
        finish_single("after_write");

        // Continuous scrolling: nine frames, offset wraps 7 -> 0 and ends at 1.
        write_row(0, 8'h80);
        scroll_en = 1'b1;
        cont = 1'b1;
        pulse_start();
        for (int i = 1; i <= 9; i++) begin
            wait_done(FRAME_BITS * 2 + 50);
            chk("cont_busy", 32'(busy), 32'd1);
            tb_off = (tb_off + 1) % COLS;
            if (i == 9) cont = 1'b0;
            else push_frame();
            @(negedge clk);
            chk("scroll_offset", 32'(offset), 32'(tb_off));
        end
        scroll_en = 1'b0;
        chk("scroll_idle", 32'(busy), 32'd0);

        // Reset in the middle of the pixel section aborts the frame at once.
        pulse_start();
        repeat (600) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_sdata", 32'(sdata), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        chk("abort_offset", 32'(offset), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        q.delete();
        for (int i = 0; i < ROWS; i++) tb_shadow[i] = '0;
        tb_off = 0;
        write_row(1, 8'h80);
        pulse_start();
        finish_single("clean");

        // DIV=2 instance: 4-cycle sclk period, one frame despite a start request while busy.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (1000) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!frame_done2 && n < FRAME_BITS * 4 + 50) begin
            @(negedge clk);
            n++;
        end
        chk("div2_done_seen", 32'(frame_done2), 32'd1);
        repeat (20) @(negedge clk);
        chk("div2_done_count", 32'(n_done2), 32'd1);
        chk("div2_busy_after", 32'(busy2), 32'd0);

        chk("sb_left", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
